// File: rtl/lock_supervisor_if.sv
// Verdict/status bundle between the lock verdict source and lock_supervisor.
// The master drives attempts and acknowledges; the slave reports status.
interface lock_supervisor_if #(
    parameter int unsigned MAX_FAIL = 3
) ();
    logic                              attempt_valid;
    logic                              unlock;
    logic                              ack;
    logic                              ready;
    logic                              door_open;
    logic                              locked_out;
    logic                              alarm;
    logic [$clog2(MAX_FAIL + 1)-1:0]   fail_cnt;

    modport master (
        output attempt_valid, unlock, ack,
        input  ready, door_open, locked_out, alarm, fail_cnt
    );

    modport slave (
        input  attempt_valid, unlock, ack,
        output ready, door_open, locked_out, alarm, fail_cnt
    );
endinterface

// File: rtl/lock_supervisor.sv
// Door/lockout supervisor fed by the lock verdict; state updates on the falling clock edge.
// Define LOCK_SUPERVISOR_ALARM_EN to escalate repeated lockouts to a latched alarm.
module lock_supervisor #(
    parameter int unsigned MAX_FAIL       = 3,
    parameter int unsigned OPEN_CYCLES    = 8,
    parameter int unsigned LOCKOUT_CYCLES = 32
) (
    input  logic              clk,
    input  logic              clear,
    lock_supervisor_if.slave  bus
);
    localparam int unsigned FW   = $clog2(MAX_FAIL + 1);
    localparam int unsigned TMAX = (OPEN_CYCLES > LOCKOUT_CYCLES) ? OPEN_CYCLES : LOCKOUT_CYCLES;
    localparam int unsigned TW   = (TMAX > 1) ? $clog2(TMAX) : 1;

    localparam logic [TW-1:0] OPEN_LOAD = TW'(OPEN_CYCLES - 1);
    localparam logic [TW-1:0] LOCK_LOAD = TW'(LOCKOUT_CYCLES - 1);
    localparam logic [FW-1:0] FAIL_LAST = FW'(MAX_FAIL - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_OPEN,
        ST_LOCKOUT
`ifdef LOCK_SUPERVISOR_ALARM_EN
        , ST_ALARM
`endif
    } state_t;

    state_t          r_state;
    logic [TW-1:0]   r_timer;
    logic [FW-1:0]   r_fail_cnt;
    logic            r_ready;
    logic            r_door_open;
    logic            r_locked_out;
`ifdef LOCK_SUPERVISOR_ALARM_EN
    logic [1:0]      r_lock_cnt;
    logic            r_alarm;
`endif

    always_ff @(negedge clk or negedge clear) begin
        if (!clear) begin
            r_state      <= ST_IDLE;
            r_timer      <= '0;
            r_fail_cnt   <= '0;
            r_ready      <= 1'b1;
            r_door_open  <= 1'b0;
            r_locked_out <= 1'b0;
`ifdef LOCK_SUPERVISOR_ALARM_EN
            r_lock_cnt   <= '0;
            r_alarm      <= 1'b0;
`endif
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (bus.attempt_valid) begin
                        if (bus.unlock) begin
                            r_fail_cnt  <= '0;
                            r_timer     <= OPEN_LOAD;
                            r_state     <= ST_OPEN;
                            r_door_open <= 1'b1;
                            r_ready     <= 1'b0;
`ifdef LOCK_SUPERVISOR_ALARM_EN
                            r_lock_cnt  <= '0;
`endif
                        end else if (r_fail_cnt == FAIL_LAST) begin
                            r_fail_cnt   <= '0;
                            r_timer      <= LOCK_LOAD;
                            r_state      <= ST_LOCKOUT;
                            r_locked_out <= 1'b1;
                            r_ready      <= 1'b0;
`ifdef LOCK_SUPERVISOR_ALARM_EN
                            if (r_lock_cnt != 2'd3) begin
                                r_lock_cnt <= r_lock_cnt + 2'd1;
                            end
`endif
                        end else begin
                            r_fail_cnt <= r_fail_cnt + 1'b1;
                        end
                    end
                end
                ST_OPEN: begin
                    if (r_timer == '0) begin
                        r_state     <= ST_IDLE;
                        r_door_open <= 1'b0;
                        r_ready     <= 1'b1;
                    end else begin
                        r_timer <= r_timer - 1'b1;
                    end
                end
                ST_LOCKOUT: begin
                    if (r_timer == '0) begin
`ifdef LOCK_SUPERVISOR_ALARM_EN
                        // locked_out stays high straight through into the alarm
                        if (r_lock_cnt >= 2'd2) begin
                            r_state <= ST_ALARM;
                            r_alarm <= 1'b1;
                        end else begin
                            r_state      <= ST_IDLE;
                            r_locked_out <= 1'b0;
                            r_ready      <= 1'b1;
                        end
`else
                        r_state      <= ST_IDLE;
                        r_locked_out <= 1'b0;
                        r_ready      <= 1'b1;
`endif
                    end else begin
                        r_timer <= r_timer - 1'b1;
                    end
                end
`ifdef LOCK_SUPERVISOR_ALARM_EN
                ST_ALARM: begin
                    if (bus.ack) begin
                        r_state      <= ST_IDLE;
                        r_alarm      <= 1'b0;
                        r_locked_out <= 1'b0;
                        r_ready      <= 1'b1;
                        r_lock_cnt   <= '0;
                        r_fail_cnt   <= '0;
                    end
                end
`endif
                default: begin
                    r_state      <= ST_IDLE;
                    r_door_open  <= 1'b0;
                    r_locked_out <= 1'b0;
                    r_ready      <= 1'b1;
                end
            endcase
        end
    end

    assign bus.ready      = r_ready;
    assign bus.door_open  = r_door_open;
    assign bus.locked_out = r_locked_out;
    assign bus.fail_cnt   = r_fail_cnt;

`ifdef LOCK_SUPERVISOR_ALARM_EN
    assign bus.alarm = r_alarm;
`else
    logic w_unused_ack;
    assign w_unused_ack = bus.ack;
    assign bus.alarm    = 1'b0;
`endif
endmodule

// File: tb/tb_lock_supervisor.sv
// Self-checking bench for lock_supervisor: directed scenarios plus random traffic,
// compared each cycle against a timestamp-based reference model.
module tb_lock_supervisor;
    localparam int unsigned MAX_FAIL       = 3;
    localparam int unsigned OPEN_CYCLES    = 8;
    localparam int unsigned LOCKOUT_CYCLES = 32;
`ifdef LOCK_SUPERVISOR_ALARM_EN
    localparam bit ALARM_EN = 1'b1;
`else
    localparam bit ALARM_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic clear;
    always #5 clk = ~clk;

    lock_supervisor_if #(.MAX_FAIL(MAX_FAIL)) bus ();

    lock_supervisor #(
        .MAX_FAIL       (MAX_FAIL),
        .OPEN_CYCLES    (OPEN_CYCLES),
        .LOCKOUT_CYCLES (LOCKOUT_CYCLES)
    ) dut (
        .clk   (clk),
        .clear (clear),
        .bus   (bus)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_eq(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    // Reference model: each window is an absolute edge interval [start, end).
    int m_cyc      = 0;
    int m_door_end = 0;
    int m_lock_end = 0;
    int m_fails    = 0;
    int m_lockouts = 0;
    bit m_alarm    = 1'b0;

    function automatic bit m_busy_after(input int c);
        return (c < m_door_end) || (c < m_lock_end) || m_alarm;
    endfunction

    task automatic model_reset();
        m_door_end = 0;
        m_lock_end = 0;
        m_fails    = 0;
        m_lockouts = 0;
        m_alarm    = 1'b0;
    endtask

    task automatic model_step(input bit av, input bit un, input bit ak);
        bit pre_ready;
        pre_ready = !m_busy_after(m_cyc);
        m_cyc++;
        if (m_alarm) begin
            if (ak) begin
                m_alarm    = 1'b0;
                m_lockouts = 0;
                m_fails    = 0;
            end
        end else if (pre_ready) begin
            if (av) begin
                if (un) begin
                    m_fails    = 0;
                    m_lockouts = 0;
                    m_door_end = m_cyc + OPEN_CYCLES;
                end else if (m_fails + 1 == MAX_FAIL) begin
                    m_fails    = 0;
                    m_lock_end = m_cyc + LOCKOUT_CYCLES;
                    if (m_lockouts < 3) m_lockouts++;
                end else begin
                    m_fails++;
                end
            end
        end else if (ALARM_EN && m_cyc == m_lock_end && m_lockouts >= 2) begin
            m_alarm = 1'b1;
        end
    endtask

    task automatic compare_all(input string tag);
        bit e_door, e_lock;
        e_door = m_cyc < m_door_end;
        e_lock = (m_cyc < m_lock_end) || m_alarm;
        check_eq({tag, ".door_open"},  int'(bus.door_open),  int'(e_door));
        check_eq({tag, ".locked_out"}, int'(bus.locked_out), int'(e_lock));
        check_eq({tag, ".ready"},      int'(bus.ready),      int'(!e_door && !e_lock));
        check_eq({tag, ".alarm"},      int'(bus.alarm),      int'(m_alarm));
        check_eq({tag, ".fail_cnt"},   int'(bus.fail_cnt),   m_fails);
    endtask

    int door_hi = 0;
    int lock_hi = 0;

    task automatic cycle(input bit av, input bit un, input bit ak);
        @(posedge clk);
        bus.attempt_valid = av;
        bus.unlock        = un;
        bus.ack           = ak;
        @(negedge clk);
        model_step(av, un, ak);
        #1;
        compare_all("cyc");
        if (bus.door_open)  door_hi++;
        if (bus.locked_out) lock_hi++;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 1'b0);
    endtask

    // Called just after a falling edge; clear is pulsed entirely inside the low phase.
    task automatic pulse_clear(input string tag);
        clear = 1'b0;
        #1;
        model_reset();
        compare_all(tag);
        check_eq({tag, ".door_now"}, int'(bus.door_open), 0);
        #1;
        clear = 1'b1;
    endtask

    initial begin
        bus.attempt_valid = 1'b0;
        bus.unlock        = 1'b0;
        bus.ack           = 1'b0;
        clear             = 1'b0;
        #12;
        compare_all("reset");
        clear = 1'b1;
        idle(2);

        // single correct attempt
        door_hi = 0;
        cycle(1'b1, 1'b1, 1'b0);
        idle(OPEN_CYCLES + 2);
        check_eq("open_len", door_hi, 8);

        // two wrong then one correct
        door_hi = 0;
        lock_hi = 0;
        cycle(1'b1, 1'b0, 1'b0);
        check_eq("fc_after1", int'(bus.fail_cnt), 1);
        cycle(1'b1, 1'b0, 1'b0);
        check_eq("fc_after2", int'(bus.fail_cnt), 2);
        cycle(1'b1, 1'b1, 1'b0);
        check_eq("fc_after_ok", int'(bus.fail_cnt), 0);
        idle(OPEN_CYCLES + 2);
        check_eq("open_len2", door_hi, 8);
        check_eq("no_lockout", lock_hi, 0);

        // three wrong -> lockout, attempts during it ignored
        lock_hi = 0;
        for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 31; i++) cycle($urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1, 1'b0);
        check_eq("fc_in_lockout", int'(bus.fail_cnt), 0);
        idle(3);
        check_eq("lock_len", lock_hi, 32);
        check_eq("ready_after_lock", int'(bus.ready), 1);

        // clear during the third cycle of OPEN
        cycle(1'b1, 1'b1, 1'b0);
        idle(2);
        pulse_clear("clr_open");
        door_hi = 0;
        cycle(1'b1, 1'b1, 1'b0);
        idle(OPEN_CYCLES + 2);
        check_eq("reopen_len", door_hi, 8);

        // six wrong attempts in two groups
        lock_hi = 0;
        for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0, 1'b0);
        idle(LOCKOUT_CYCLES + 1);
        for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0, 1'b0);
        idle(LOCKOUT_CYCLES + 50);
`ifdef LOCK_SUPERVISOR_ALARM_EN
        check_eq("alarm_held", int'(bus.alarm), 1);
        check_eq("alarm_ready", int'(bus.ready), 0);
        cycle(1'b0, 1'b0, 1'b1);
        check_eq("ack_alarm", int'(bus.alarm), 0);
        check_eq("ack_ready", int'(bus.ready), 1);
`else
        check_eq("no_alarm", int'(bus.alarm), 0);
        check_eq("two_lockouts", lock_hi, 64);
        check_eq("ready_end", int'(bus.ready), 1);
`endif

        // random traffic
        for (int i = 0; i < 3000; i++) begin
            cycle($urandom_range(0, 2) == 0, $urandom_range(0, 4) == 0, $urandom_range(0, 7) == 0);
            if ($urandom_range(0, 299) == 0) pulse_clear("clr_rand");
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
